fifo_wr_arbiter: RTL
====================

# fifo_wr_arbiter

Round-robin write-port arbiter that shares one synchronous FIFO write port among NUM_REQ producers using per-requester valid/ready handshakes. It grants bounded bursts and tracks FIFO occupancy with its own credit counter, because the FIFO's full flag lags by a cycle. It sits directly in front of the FIFO and drives its write_en/data_in. It observes successful FIFO reads to return credits.

## Interface
Parameters:
- NUM_REQ, 4, number of producers (2..8)
- DATA_WIDTH, 16, beat width
- DEPTH, 8, FIFO depth; sets the credit ceiling
- MAX_BURST, 4, maximum beats per grant (≥1)

Ports:
- clk  in  1  clock
- reset_n  in  1  reset: asynchronous, active-low
- req_valid  in  NUM_REQ  per-requester beat valid
- req_last  in  NUM_REQ  beat is the last of the requester's packet
- req_data  in  NUM_REQ*DATA_WIDTH  requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
- req_ready  out  NUM_REQ  beat accepted when valid&&ready; at most one bit set
- fifo_write_en  out  1  registered write strobe to the FIFO
- fifo_data_in  out  DATA_WIDTH  registered write data
- fifo_pop  in  1  one FIFO read actually performed (read_en && !empty), one pulse per entry
- grant_id  out  $clog2(NUM_REQ)  current or last owner
- busy  out  1  state is BURST
- credits  out  $clog2(DEPTH+1)  free FIFO entries as tracked
- credit_err  out  1  sticky; set when fifo_pop arrives while credits==DEPTH

## Operation
- FSM states: IDLE, BURST.
- IDLE:
  - If any req_valid is set and credits>0, select the first valid requester scanning from rr_ptr upward, with wrap.
  - Register the winner into grant_id, clear beat_cnt, and go to BURST.
  - req_ready is all-zero in IDLE.
- BURST:
  - req_ready[grant_id] = (credits>0). All other ready bits are 0.
  - An accepted beat is captured into fifo_data_in with fifo_write_en=1 on the next cycle. beat_cnt increments.
  - Exit to IDLE after an accepted beat with req_last=1, or with beat_cnt+1==MAX_BURST.
  - Also exit to IDLE in any cycle where req_valid[grant_id]=0; no beat is accepted in that cycle.
  - A stall with credits==0 and valid high holds BURST. beat_cnt is unchanged.
- On exit from BURST, rr_ptr = (grant_id+1) mod NUM_REQ, giving fairness across packets and bursts.
- Credit arithmetic:
  - Decrement by 1 on an accepted beat. Increment by 1 on fifo_pop. Both in the same cycle: unchanged.
  - Range is 0..DEPTH.
  - fifo_pop at credits==DEPTH with no accept: credits saturate and credit_err is set.
- Because credits are charged at acceptance, the FIFO can never overflow. The FIFO full flag is not an input.
- Requester data need not be held after acceptance. Bursts interrupted at MAX_BURST resume after re-arbitration.

## Timing
- Reset values:
  - state=IDLE, rr_ptr=0, grant_id=0, beat_cnt=0
  - credits=DEPTH, credit_err=0
  - req_ready=0, fifo_write_en=0, fifo_data_in=0, busy=0
- Arbitration: 1 bubble cycle per grant (IDLE→BURST). First accept is in the cycle after the request is seen.
- Write latency: accept in cycle t → fifo_write_en/fifo_data_in valid in cycle t+1 for exactly one cycle.
- Peak throughput: MAX_BURST beats per MAX_BURST+1 cycles.
- req_ready depends only on registered state and credits. There is no combinational path from req_valid to req_ready.
- credits update on the edge after the accept or pop event. The credits output is registered.
- Asserting reset_n low mid-burst drops to reset values immediately. An in-flight fifo_write_en is cancelled, and the FIFO must be reset together with this block.

## Structure
- Package fifo_arb_pkg: state_t enum {IDLE, BURST}, and a function computing the grant-id width from NUM_REQ.
- Sub-module rr_arbiter: purely combinational rotate-priority pick. Inputs are the request vector and rr_ptr; outputs are found and idx. Instantiated once.
- Top: FSM, beat counter, credit counter, output registers.

## Test plan
- Single requester: req 0 sends 3 beats (0xA1, 0xA2, 0xA3, last on 3rd) → fifo_data_in shows A1, A2, A3 on consecutive cycles starting 2 cycles after valid rises; credits goes 8→5; then IDLE.
- Fairness: reqs 0–3 all valid, 6-beat packets, MAX_BURST=4, with a pop every cycle → grant order 0,1,2,3,0,…; each grant is 4 beats then 2 beats; no requester is skipped.
- Credit stall: no pops, req 1 streams 10 beats → exactly 8 writes, req_ready low with credits==0; one fifo_pop → exactly one more beat accepted.
- Simultaneous accept and pop at credits==3 → credits stays 3 and the write proceeds.
- Valid drop: req 2 deasserts valid mid-burst after 2 beats → FSM returns to IDLE, rr_ptr=3, a waiting req 3 is granted next.
- Reset mid-burst with 5 credits used → all outputs return to reset values (credits=8, fifo_write_en=0); spurious fifo_pop afterwards → credit_err=1 and credits stays 8.

Source files
------------

// File: rtl/fifo_wr_arbiter_pkg.sv
// fifo_arb_pkg: shared FSM state type and sizing helper for the FIFO write-port arbiter.
// Revision 1.0
`default_nettype none

package fifo_arb_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  // Grant-id width; never below one bit so a 2-requester build still has a usable index.
  function automatic int gid_width(input int num_req);
    return (num_req <= 2) ? 1 : $clog2(num_req);
  endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_wr_arbiter_rr_arbiter.sv
// rr_arbiter: combinational rotate-priority pick of the first set request at or above rr_ptr_i.
// Revision 1.0
`default_nettype none

module rr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  localparam int GW = gid_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [GW-1:0]      rr_ptr_i,
  output logic               found_o,
  output logic [GW-1:0]      idx_o
);

  // Scan from the farthest offset down so the nearest candidate is written last and wins.
  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      int pos;
      pos = int'(rr_ptr_i) + k;
      if (pos >= NUM_REQ) pos = pos - NUM_REQ;
      if (req_i[pos]) begin
        found_o = 1'b1;
        idx_o   = GW'(pos);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin burst arbiter sharing one FIFO write port, with credit-based flow control.
// Revision 1.0
`default_nettype none

module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 8,
  parameter int MAX_BURST  = 4
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_last,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          fifo_write_en,
  output logic [DATA_WIDTH-1:0]         fifo_data_in,
  input  logic                          fifo_pop,
  output logic [gid_width(NUM_REQ)-1:0] grant_id,
  output logic                          busy,
  output logic [$clog2(DEPTH+1)-1:0]    credits,
  output logic                          credit_err
);

  localparam int GW = gid_width(NUM_REQ);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] CRED_MAX   = CW'(DEPTH);
  localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST - 1);

  state_t                  state_q;
  logic [GW-1:0]           rr_ptr_q, grant_id_q, next_ptr;
  logic [BW-1:0]           beat_cnt_q;
  logic [CW-1:0]           credits_q, credits_d;
  logic                    credit_err_q, credit_err_d;
  logic                    fifo_we_q;
  logic [DATA_WIDTH-1:0]   fifo_data_q;

  logic                    arb_found;
  logic [GW-1:0]           arb_idx;
  logic                    credit_ok, cur_valid, cur_last, accept;
  logic [DATA_WIDTH-1:0]   cur_data;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr_arbiter (
    .req_i    (req_valid),
    .rr_ptr_i (rr_ptr_q),
    .found_o  (arb_found),
    .idx_o    (arb_idx)
  );

  assign credit_ok = (credits_q != '0);
  assign cur_valid = req_valid[grant_id_q];
  assign cur_last  = req_last[grant_id_q];
  assign cur_data  = req_data[int'(grant_id_q)*DATA_WIDTH +: DATA_WIDTH];
  assign accept    = (state_q == BURST) && cur_valid && credit_ok;
  assign next_ptr  = (grant_id_q == GW'(NUM_REQ - 1)) ? '0 : grant_id_q + 1'b1;

  // Ready is a function of registered state only, never of req_valid.
  always_comb begin
    req_ready = '0;
    if (state_q == BURST && credit_ok) req_ready[grant_id_q] = 1'b1;
  end

  always_comb begin
    credits_d    = credits_q;
    credit_err_d = credit_err_q;
    if (accept && !fifo_pop) begin
      credits_d = credits_q - 1'b1;
    end else if (fifo_pop && !accept) begin
      if (credits_q == CRED_MAX) credit_err_d = 1'b1;
      else                       credits_d    = credits_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      grant_id_q   <= '0;
      beat_cnt_q   <= '0;
      credits_q    <= CRED_MAX;
      credit_err_q <= 1'b0;
      fifo_we_q    <= 1'b0;
      fifo_data_q  <= '0;
    end else begin
      credits_q    <= credits_d;
      credit_err_q <= credit_err_d;
      fifo_we_q    <= accept;
      if (accept) fifo_data_q <= cur_data;
      case (state_q)
        IDLE: begin
          if (arb_found && credit_ok) begin
            grant_id_q <= arb_idx;
            beat_cnt_q <= '0;
            state_q    <= BURST;
          end
        end
        BURST: begin
          if (!cur_valid) begin
            state_q  <= IDLE;
            rr_ptr_q <= next_ptr;
          end else if (credit_ok) begin
            beat_cnt_q <= beat_cnt_q + 1'b1;
            if (cur_last || beat_cnt_q == BURST_LAST) begin
              state_q  <= IDLE;
              rr_ptr_q <= next_ptr;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign fifo_write_en = fifo_we_q;
  assign fifo_data_in  = fifo_data_q;
  assign grant_id      = grant_id_q;
  assign busy          = (state_q == BURST);
  assign credits       = credits_q;
  assign credit_err    = credit_err_q;

endmodule

`default_nettype wire
